mm_reg_bridge: RTL and testbench

MM_REG_BRIDGE -- requirements
Module: mm_reg_bridge

---
 rtl/mm_reg_bridge_pkg.sv | 40 ++++
 rtl/mm_reg_bridge_if.sv | 46 ++++
 rtl/mm_reg_bridge_timer.sv | 25 ++
 rtl/mm_reg_bridge.sv | 117 +++++++++++
 tb/tb_mm_reg_bridge.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mm_reg_bridge_pkg.sv
// Shared widths, defaults and FSM state encoding for the mm_reg_bridge slice.
// XLEN, XLEN_BYTES and MM_REG_ADDR_BITS may be overridden by the build.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef XLEN_BYTES
`define XLEN_BYTES 4
`endif
`ifndef MM_REG_ADDR_BITS
`define MM_REG_ADDR_BITS 8
`endif

package mm_reg_bridge_pkg;

    localparam int XLEN       = `XLEN;
    localparam int XLEN_BYTES = `XLEN_BYTES;
    localparam int ADDR_BITS  = `MM_REG_ADDR_BITS;

    localparam logic [31:0] DEFAULT_BASE_ADDR      = 32'h2000_0000;
    localparam logic [7:0]  DEFAULT_TIMEOUT_CYCLES = 8'd15;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT  = 3'd1,
        WR_ISSUE = 3'd2,
        WR_WAIT  = 3'd3,
        RESP     = 3'd4
    } state_e;

    localparam logic [2:0] S_IDLE     = IDLE;
    localparam logic [2:0] S_RD_WAIT  = RD_WAIT;
    localparam logic [2:0] S_WR_ISSUE = WR_ISSUE;
    localparam logic [2:0] S_WR_WAIT  = WR_WAIT;
    localparam logic [2:0] S_RESP     = RESP;

    function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
        return addr[31:ADDR_BITS+2] == base[31:ADDR_BITS+2];
    endfunction

endpackage

// File: rtl/mm_reg_bridge_if.sv
// Core-side memory port plus split read/write register-bus port of the bridge.
// Modport slave is the bridge; modport master is the core/peripheral environment.
interface mm_reg_bridge_if;
    import mm_reg_bridge_pkg::*;

    logic                  mem_req;
    logic                  mem_we;
    logic [31:0]           mem_addr;
    logic [XLEN_BYTES-1:0] mem_byte_en;
    logic [XLEN-1:0]       mem_wdata;
    logic                  mem_ready;
    logic                  mem_ack;
    logic                  mem_err;
    logic [XLEN-1:0]       mem_rdata;

    logic                  WB_RD_STB_O;
    logic [ADDR_BITS-1:0]  WB_RD_ADR_O;
    logic [XLEN-1:0]       WB_RD_DAT_I;
    logic                  WB_RD_ACK_I;

    logic                  WB_WR_STB_O;
    logic                  WB_WR_WE_O;
    logic [XLEN_BYTES-1:0] WB_WR_SEL_O;
    logic [ADDR_BITS-1:0]  WB_WR_ADR_O;
    logic [XLEN-1:0]       WB_WR_DAT_O;
    logic                  WB_WR_ACK_I;

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_byte_en, mem_wdata,
        output mem_ready, mem_ack, mem_err, mem_rdata,
        output WB_RD_STB_O, WB_RD_ADR_O,
        input  WB_RD_DAT_I, WB_RD_ACK_I,
        output WB_WR_STB_O, WB_WR_WE_O, WB_WR_SEL_O, WB_WR_ADR_O, WB_WR_DAT_O,
        input  WB_WR_ACK_I
    );

    modport master (
        output mem_req, mem_we, mem_addr, mem_byte_en, mem_wdata,
        input  mem_ready, mem_ack, mem_err, mem_rdata,
        input  WB_RD_STB_O, WB_RD_ADR_O,
        output WB_RD_DAT_I, WB_RD_ACK_I,
        input  WB_WR_STB_O, WB_WR_WE_O, WB_WR_SEL_O, WB_WR_ADR_O, WB_WR_DAT_O,
        output WB_WR_ACK_I
    );

endinterface

// File: rtl/mm_reg_bridge_timer.sv
// Wait-cycle counter for the bridge ack timeout; expired flags the last allowed wait cycle.
// Only instantiated when MM_REG_BRIDGE_TIMEOUT_EN is defined.
module mm_reg_bridge_timer (
    input  logic       clk,
    input  logic       sync_reset,
    input  logic       i_clear,
    input  logic       i_enable,
    input  logic [7:0] i_limit,
    output logic       o_expired
);

    logic [7:0] r_count;

    // Count holds the index (from 0) of the current wait cycle.
    assign o_expired = i_enable && (r_count == i_limit - 8'd1);

    always_ff @(posedge clk) begin
        if (sync_reset || i_clear) begin
            r_count <= 8'd0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 8'd1;
        end
    end

endmodule

// File: rtl/mm_reg_bridge.sv
// Core memory port to split read/write register bus bridge, one access at a time.
// Define MM_REG_BRIDGE_TIMEOUT_EN to abort wait states after TIMEOUT_CYCLES with mem_err.
module mm_reg_bridge
    import mm_reg_bridge_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
    parameter logic [7:0]  TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input logic            clk,
    input logic            sync_reset,
    mm_reg_bridge_if.slave bus
);

    logic [2:0]            r_state;
    logic [2:0]            w_state_next;
    logic [ADDR_BITS-1:0]  r_rd_adr;
    logic [ADDR_BITS-1:0]  r_wr_adr;
    logic [XLEN-1:0]       r_wdata;
    logic [XLEN_BYTES-1:0] r_sel;
    logic [XLEN-1:0]       r_rdata;
    logic                  r_err;
    logic                  w_in_win;
    logic                  w_accept;
    logic                  w_waiting;
    logic                  w_wait_ack;
    logic                  w_expired;
    logic                  w_unused;

    assign w_in_win   = in_window(bus.mem_addr, BASE_ADDR);
    assign w_accept   = (r_state == S_IDLE) && bus.mem_req;
    assign w_waiting  = (r_state == S_RD_WAIT) || (r_state == S_WR_WAIT);
    assign w_wait_ack = ((r_state == S_RD_WAIT) && bus.WB_RD_ACK_I)
                     || ((r_state == S_WR_WAIT) && bus.WB_WR_ACK_I);

`ifdef MM_REG_BRIDGE_TIMEOUT_EN
    logic w_timer_clear;
    assign w_timer_clear = !w_waiting;
    assign w_unused      = ^bus.mem_addr[1:0];

    mm_reg_bridge_timer u_timer (
        .clk        (clk),
        .sync_reset (sync_reset),
        .i_clear    (w_timer_clear),
        .i_enable   (w_waiting),
        .i_limit    (TIMEOUT_CYCLES),
        .o_expired  (w_expired)
    );
`else
    assign w_expired = 1'b0;
    assign w_unused  = ^{TIMEOUT_CYCLES, bus.mem_addr[1:0]};
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.mem_req) begin
                    if (!w_in_win)       w_state_next = S_RESP;
                    else if (bus.mem_we) w_state_next = S_WR_ISSUE;
                    else                 w_state_next = S_RD_WAIT;
                end
            end
            S_RD_WAIT:  if (w_wait_ack || w_expired) w_state_next = S_RESP;
            S_WR_ISSUE: w_state_next = S_WR_WAIT;
            S_WR_WAIT:  if (w_wait_ack || w_expired) w_state_next = S_RESP;
            S_RESP:     w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            r_state  <= S_IDLE;
            r_rd_adr <= '0;
            r_wr_adr <= '0;
            r_wdata  <= '0;
            r_sel    <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_err   <= !w_in_win;
                r_rdata <= '0;
                // Write-side registers only move on writes so the bus holds its last value.
                if (w_in_win && bus.mem_we) begin
                    r_wr_adr <= bus.mem_addr[ADDR_BITS+1:2];
                    r_wdata  <= bus.mem_wdata;
                    r_sel    <= bus.mem_byte_en;
                end
                if (w_in_win && !bus.mem_we) begin
                    r_rd_adr <= bus.mem_addr[ADDR_BITS+1:2];
                end
            end
            if ((r_state == S_RD_WAIT) && bus.WB_RD_ACK_I) begin
                r_rdata <= bus.WB_RD_DAT_I;
            end
            if (w_waiting && w_expired && !w_wait_ack) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.mem_ready   = (r_state == S_IDLE);
    assign bus.mem_ack     = (r_state == S_RESP);
    assign bus.mem_err     = (r_state == S_RESP) && r_err;
    assign bus.mem_rdata   = ((r_state == S_RESP) && !r_err) ? r_rdata : '0;

    assign bus.WB_RD_STB_O = (r_state == S_RD_WAIT);
    assign bus.WB_RD_ADR_O = r_rd_adr;
    assign bus.WB_WR_STB_O = (r_state == S_WR_ISSUE) || (r_state == S_WR_WAIT);
    assign bus.WB_WR_WE_O  = (r_state == S_WR_ISSUE);
    assign bus.WB_WR_SEL_O = r_sel;
    assign bus.WB_WR_ADR_O = r_wr_adr;
    assign bus.WB_WR_DAT_O = r_wdata;

endmodule

// File: tb/tb_mm_reg_bridge.sv
// Self-checking bench for mm_reg_bridge: transaction-level timeline model plus per-cycle compare.
// Timeout scenarios follow MM_REG_BRIDGE_TIMEOUT_EN when it is defined for the build.
module tb_mm_reg_bridge;
    import mm_reg_bridge_pkg::*;

    localparam logic [31:0] BASE = 32'h2000_0000;
    localparam int          T    = 15;
`ifdef MM_REG_BRIDGE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic sync_reset;

    mm_reg_bridge_if bus ();

    mm_reg_bridge #(
        .BASE_ADDR      (BASE),
        .TIMEOUT_CYCLES (8'(T))
    ) dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected outputs for the current cycle, set by the stimulus timeline.
    bit          cmp_en;
    bit          e_ready, e_ack, e_err, e_rdchk, e_rd_stb, e_wr_stb, e_we;
    logic [31:0] e_rdata;
    logic [7:0]  e_rd_adr;
    logic [7:0]  m_wr_adr;
    logic [31:0] m_wr_dat;
    logic [3:0]  m_wr_sel;

    // Monitor results used by the literal checks.
    int          cyc, last_lat, we_cnt, ack_cnt;
    logic        last_err;
    logic [31:0] last_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("mem_ready", 32'(bus.mem_ready), 32'(e_ready));
            chk("mem_ack", 32'(bus.mem_ack), 32'(e_ack));
            chk("mem_err", 32'(bus.mem_err), 32'(e_err));
            if (!e_ack || e_rdchk) chk("mem_rdata", bus.mem_rdata, e_rdata);
            chk("rd_stb", 32'(bus.WB_RD_STB_O), 32'(e_rd_stb));
            if (e_rd_stb) chk("rd_adr", 32'(bus.WB_RD_ADR_O), 32'(e_rd_adr));
            chk("wr_stb", 32'(bus.WB_WR_STB_O), 32'(e_wr_stb));
            chk("wr_we", 32'(bus.WB_WR_WE_O), 32'(e_we));
            chk("wr_adr", 32'(bus.WB_WR_ADR_O), 32'(m_wr_adr));
            chk("wr_dat", bus.WB_WR_DAT_O, m_wr_dat);
            chk("wr_sel", 32'(bus.WB_WR_SEL_O), 32'(m_wr_sel));
            if (bus.mem_ack) begin
                last_lat   = cyc;
                last_err   = bus.mem_err;
                last_rdata = bus.mem_rdata;
                ack_cnt++;
            end
            if (bus.WB_WR_WE_O) we_cnt++;
            if (bus.mem_ready && bus.mem_req) begin
                cyc    = 1;
                we_cnt = 0;
            end else begin
                cyc++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input bit ready);
        e_ready = ready; e_ack = 1'b0; e_err = 1'b0; e_rdchk = 1'b1; e_rdata = '0;
        e_rd_stb = 1'b0; e_wr_stb = 1'b0; e_we = 1'b0;
    endtask

    // Inputs while the bridge is busy: request lines are don't-care, acks are placed explicitly.
    task automatic busy_inputs(input bit hold);
        bus.WB_RD_ACK_I = 1'b0;
        bus.WB_WR_ACK_I = 1'b0;
        if (!hold) begin
            bus.mem_req     = 1'($urandom);
            bus.mem_we      = 1'($urandom);
            bus.mem_addr    = $urandom;
            bus.mem_byte_en = 4'($urandom);
            bus.mem_wdata   = $urandom;
        end
    endtask

    task automatic quiet(input bit hold);
        bus.WB_RD_ACK_I = 1'b0;
        bus.WB_WR_ACK_I = 1'b0;
        if (!hold) bus.mem_req = 1'b0;
    endtask

    // One access: d is the peripheral's ack delay in cycles after it first sees the strobe/WE.
    task automatic xfer(input bit we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata, input int d, input logic [31:0] pdata,
                        input bit hold);
        logic [31:0] base_v;
        logic [7:0]  word;
        bit          inwin, to;
        int          w, n_wait;
        base_v   = BASE;
        word     = addr[ADDR_BITS+1:2];
        inwin    = (addr[31:ADDR_BITS+2] == base_v[31:ADDR_BITS+2]);
        last_lat = -1;
        set_exp(1'b1);
        bus.mem_req     = 1'b1;
        bus.mem_we      = we;
        bus.mem_addr    = addr;
        bus.mem_byte_en = be;
        bus.mem_wdata   = wdata;
        bus.WB_RD_ACK_I = 1'($urandom);
        bus.WB_WR_ACK_I = 1'($urandom);
        bus.WB_RD_DAT_I = $urandom;
        step();
        set_exp(1'b0);
        busy_inputs(hold);
        if (!inwin) begin
            e_ack = 1'b1; e_err = 1'b1;
            bus.WB_RD_ACK_I = 1'($urandom);
            bus.WB_WR_ACK_I = 1'($urandom);
            step();
        end else begin
            // Read strobe is seen one cycle earlier than the write-wait phase starts.
            w      = we ? d : d + 1;
            to     = TO_EN && (w > T);
            n_wait = to ? T : w;
            if (we) begin
                m_wr_adr = word; m_wr_dat = wdata; m_wr_sel = be;
                e_wr_stb = 1'b1; e_we = 1'b1;
                step();
                busy_inputs(hold);
            end
            for (int i = 1; i <= n_wait; i++) begin
                e_rd_stb = !we; e_wr_stb = we; e_we = 1'b0; e_rd_adr = word;
                bus.WB_RD_ACK_I = !we && (i == w);
                bus.WB_WR_ACK_I = we && (i == w);
                bus.WB_RD_DAT_I = (i == w) ? pdata : $urandom;
                step();
                busy_inputs(hold);
            end
            set_exp(1'b0);
            e_ack = 1'b1; e_err = to; e_rdchk = to || !we;
            e_rdata = (to || we) ? 32'h0 : pdata;
            if (to) begin
                bus.WB_RD_ACK_I = !we && (w == T + 1);
                bus.WB_WR_ACK_I = we && (w == T + 1);
            end else begin
                bus.WB_RD_ACK_I = 1'($urandom);
                bus.WB_WR_ACK_I = 1'($urandom);
            end
            bus.WB_RD_DAT_I = $urandom;
            step();
            // A timed-out peripheral still acks late; it must be ignored in IDLE.
            if (to) begin
                for (int i = T + 2; i <= w; i++) begin
                    set_exp(1'b1);
                    quiet(hold);
                    bus.WB_RD_ACK_I = !we && (i == w);
                    bus.WB_WR_ACK_I = we && (i == w);
                    step();
                end
            end
        end
        set_exp(1'b1);
        quiet(hold);
    endtask

    task automatic reset_mid_read();
        int acks_before;
        set_exp(1'b1);
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = BASE + 32'h10;
        step();
        set_exp(1'b0);
        quiet(1'b0);
        e_rd_stb = 1'b1; e_rd_adr = 8'd4;
        step();
        step();
        sync_reset = 1'b1;
        step();
        sync_reset = 1'b0;
        acks_before = ack_cnt;
        set_exp(1'b1);
        m_wr_adr = '0; m_wr_dat = '0; m_wr_sel = '0;
        bus.WB_RD_ACK_I = 1'b1;
        bus.WB_RD_DAT_I = 32'hBAD0_0001;
        step();
        quiet(1'b0);
        step();
        chk("reset_drops_ack", 32'(ack_cnt - acks_before), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cmp_en = 1'b0; sync_reset = 1'b1;
        cyc = 0; last_lat = -1; we_cnt = 0; ack_cnt = 0;
        last_err = 1'b0; last_rdata = '0;
        m_wr_adr = '0; m_wr_dat = '0; m_wr_sel = '0;
        set_exp(1'b1);
        bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = '0;
        bus.mem_byte_en = '0; bus.mem_wdata = '0;
        bus.WB_RD_DAT_I = '0; bus.WB_RD_ACK_I = 1'b0; bus.WB_WR_ACK_I = 1'b0;
        step();
        cmp_en = 1'b1;
        step();
        sync_reset = 1'b0;
        chk("reset_ready", 32'(bus.mem_ready), 32'd1);
        chk("reset_wr_dat", bus.WB_WR_DAT_O, 32'd0);

        xfer(1'b0, 32'h2000_0008, 4'h0, 32'h0, 1, 32'hDEAD_BEEF, 1'b0);
        chk("read_latency", 32'(last_lat), 32'd3);
        chk("read_rdata", last_rdata, 32'hDEAD_BEEF);
        chk("read_err", 32'(last_err), 32'd0);

        xfer(1'b1, 32'h2000_0004, 4'b0011, 32'h1234_5678, 1, 32'h0, 1'b0);
        chk("write_latency", 32'(last_lat), 32'd3);
        chk("write_we_pulses", 32'(we_cnt), 32'd1);
        chk("write_sel_held", 32'(bus.WB_WR_SEL_O), 32'h3);
        chk("write_adr_held", 32'(bus.WB_WR_ADR_O), 32'd1);

        xfer(1'b0, 32'h1000_0000, 4'h0, 32'h0, 1, 32'h5555_5555, 1'b0);
        chk("oow_latency", 32'(last_lat), 32'd1);
        chk("oow_err", 32'(last_err), 32'd1);
        chk("oow_rdata", last_rdata, 32'd0);

        if (TO_EN) begin
            xfer(1'b0, BASE + 32'h20, 4'h0, 32'h0, 14, 32'hCAFE_0001, 1'b0);
            chk("to_edge_read_err", 32'(last_err), 32'd0);
            chk("to_edge_read_lat", 32'(last_lat), 32'd16);
            xfer(1'b0, BASE + 32'h20, 4'h0, 32'h0, 25, 32'hCAFE_0002, 1'b0);
            chk("to_read_err", 32'(last_err), 32'd1);
            chk("to_read_lat", 32'(last_lat), 32'd16);
            xfer(1'b1, BASE + 32'h24, 4'hF, 32'hA5A5_0003, 15, 32'h0, 1'b0);
            chk("to_edge_write_err", 32'(last_err), 32'd0);
            xfer(1'b1, BASE + 32'h24, 4'hC, 32'hA5A5_0004, 16, 32'h0, 1'b0);
            chk("to_write_err", 32'(last_err), 32'd1);
            chk("to_write_lat", 32'(last_lat), 32'd17);
        end else begin
            xfer(1'b0, BASE + 32'h20, 4'h0, 32'h0, 30, 32'hCAFE_0005, 1'b0);
            chk("slow_read_lat", 32'(last_lat), 32'd32);
            chk("slow_read_err", 32'(last_err), 32'd0);
        end

        xfer(1'b0, BASE + 32'h08, 4'h0, 32'h0, 1, 32'h1111_1111, 1'b1);
        xfer(1'b0, BASE + 32'h0C, 4'h0, 32'h0, 2, 32'h2222_2222, 1'b0);
        chk("b2b_second_rdata", last_rdata, 32'h2222_2222);
        chk("b2b_second_lat", 32'(last_lat), 32'd4);

        reset_mid_read();

        for (int n = 0; n < 150; n++) begin
            logic [31:0] a, base_v;
            int          d;
            base_v = BASE;
            if ($urandom_range(0, 7) == 0) begin
                a = $urandom;
                if (a[31:ADDR_BITS+2] == base_v[31:ADDR_BITS+2]) a[31] = ~a[31];
            end else begin
                a = {base_v[31:ADDR_BITS+2], 8'($urandom), 2'($urandom)};
            end
            d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 20))
                                            : int'($urandom_range(1, 4));
            xfer(1'($urandom), a, 4'($urandom), $urandom, d, $urandom, 1'b0);
            if ($urandom_range(0, 3) == 0) step();
        end

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
